// File: rtl/execute_unit_mc.sv
// execute_unit_mc: Y-86 execute stage with registered CC, multi-cycle signed mulq and E->M pipeline register
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   E_stat/E_icode/E_ifun            instruction status, opcode and function from the E register
//   E_valA/E_valB/E_valC             signed operands
//   E_destE/E_destM                  destination registers (4'hF = none)
//   setcc                            CC write permission from the pipeline controller
//   M_bubble                         loads a bubble into M and aborts an in-flight multiply
//   e_valE/e_destE/e_Cnd             combinational execute result, qualified destE, condition
//   e_busy                           multiply in progress, E must be held
//   cc                               registered {OF,SF,ZF}
//   M_*                              pipeline register toward the memory stage
module execute_unit_mc #(
    parameter int W      = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    input  logic [3:0]   E_destE,
    input  logic [3:0]   E_destM,
    input  logic         setcc,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_destE,
    output logic         e_Cnd,
    output logic         e_busy,
    output logic [2:0]   cc,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_destE,
    output logic [3:0]   M_destM
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc, term, prod;
    logic [W-1:0]   sum, diff, abs_a, abs_b, mul_lo, op_res;
    logic           is_op, is_mul, op_ok, start, neg, of, sxo, cond, cc_load, bubble;

    assign sum    = E_valB + E_valA;
    assign diff   = E_valB - E_valA;
    assign is_op  = E_icode == 4'h6;
    assign is_mul = is_op && E_ifun == 4'h4 && MUL_EN;
    assign op_ok  = is_op && (E_ifun < 4'h4 || is_mul);
    assign start  = state == IDLE && is_mul && !M_bubble;
    assign e_busy = start || state == RUN;

    // Unsigned shift-add on magnitudes; sign applied afterwards. The most negative
    // value's magnitude 2^(W-1) is still representable as a W-bit unsigned number.
    assign neg    = E_valA[W-1] ^ E_valB[W-1];
    assign abs_a  = E_valA[W-1] ? -E_valA : E_valA;
    assign abs_b  = E_valB[W-1] ? -E_valB : E_valB;
    assign term   = abs_a[cnt] ? ({{W{1'b0}}, abs_b} << cnt) : '0;
    assign prod   = neg ? -acc : acc;
    assign mul_lo = state == DONE ? prod[W-1:0] : '0;

    always_comb begin
        op_res = '0;
        of     = 1'b0;
        case (E_ifun)
            4'h0: begin
                op_res = sum;
                of     = E_valA[W-1] == E_valB[W-1] && sum[W-1] != E_valA[W-1];
            end
            4'h1: begin
                op_res = diff;
                of     = E_valA[W-1] != E_valB[W-1] && diff[W-1] != E_valB[W-1];
            end
            4'h2: op_res = E_valA & E_valB;
            4'h3: op_res = E_valA ^ E_valB;
            4'h4: begin
                op_res = MUL_EN ? mul_lo : '0;
                of     = MUL_EN && prod[2*W-1:W] != {W{prod[W-1]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        e_valE = '0;
        case (E_icode)
            4'h2:       e_valE = E_valA;
            4'h3:       e_valE = E_valC;
            4'h4, 4'h5: e_valE = E_valB + E_valC;
            4'h6:       e_valE = op_res;
            4'h8, 4'hA: e_valE = E_valB - W'(8);
            4'h9, 4'hB: e_valE = E_valB + W'(8);
            default:    ;
        endcase
    end

    assign sxo = cc[1] ^ cc[2];

    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = sxo | cc[0];
            4'h2:    cond = sxo;
            4'h3:    cond = cc[0];
            4'h4:    cond = ~cc[0];
            4'h5:    cond = ~sxo;
            4'h6:    cond = ~sxo & ~cc[0];
            default: ;
        endcase
    end

    assign e_Cnd   = (E_icode == 4'h2 || E_icode == 4'h7) && cond;
    assign e_destE = (E_icode == 4'h2 && !e_Cnd) ? 4'hF : E_destE;
    assign cc_load = op_ok && setcc && !e_busy && !M_bubble;
    assign bubble  = M_bubble || e_busy;

    always_comb begin
        state_nx = state;
        if (M_bubble)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = is_mul ? RUN : IDLE;
                RUN:     state_nx = cnt == CW'(W - 1) ? DONE : RUN;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Iteration i happens on the edge leaving the cycle with cnt==i; the start edge
    // out of IDLE performs iteration 0, so RUN lasts W-1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (e_busy && !M_bubble) begin
            acc <= (state == RUN ? acc : '0) + term;
            cnt <= state_nx == DONE ? '0 : cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cc <= 3'b001;
        else if (cc_load)
            cc <= {of, op_res[W-1], op_res == '0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            M_stat  <= 4'h1;
            M_icode <= 4'h1;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_destE <= 4'hF;
            M_destM <= 4'hF;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_destE <= e_destE;
            M_destM <= E_destM;
        end
    end
endmodule
